// File: rtl/cpu_mem_ctrl.sv
// Single-port word memory shared by the accumulator CPU (while running) and a host
// load/dump port (while halted), with programmable wait states and a write-protected program region.
module cpu_mem_ctrl #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 1,
   parameter int PROT_LIMIT  = 401
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_end,
   input  logic              cpu_req,
   input  logic              read_write,
   input  logic [ADDR_W-1:0] memory_address,
   input  logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] data_in,
   output logic              cpu_ready,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ready,
   output logic              busy,
   output logic              prot_err,
   output logic [ADDR_W-1:0] err_addr,
   output logic [1:0]        state_dbg
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state;
   logic [2:0]          wait_cnt;
   logic                own_host;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                blocked;
   logic                mem_we;

   // Handshake: a master raises req with address/data stable and keeps them until its
   // ready pulses for one cycle; req must drop the cycle after ready, otherwise it is
   // taken as a new access at the next IDLE.
   assign blocked   = !own_host && lat_we && (32'(lat_addr) < PROT_LIMIT);
   assign mem_we    = (state == S_ACCESS) && lat_we && !blocked;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[lat_addr] <= lat_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         own_host   <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         data_in    <= '0;
         host_rdata <= '0;
         cpu_ready  <= 1'b0;
         host_ready <= 1'b0;
         busy       <= 1'b0;
         prot_err   <= 1'b0;
         err_addr   <= '0;
      end else begin
         cpu_ready  <= 1'b0;
         host_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_end && cpu_req) begin
                  own_host  <= 1'b0;
                  lat_we    <= read_write;
                  lat_addr  <= memory_address;
                  lat_wdata <= data_out;
                  wait_cnt  <= 3'(WAIT_STATES);
                  busy      <= 1'b1;
                  state     <= S_WAIT;
               end else if (!start_end && host_req) begin
                  own_host  <= 1'b1;
                  lat_we    <= host_we;
                  lat_addr  <= host_addr;
                  lat_wdata <= host_wdata;
                  wait_cnt  <= 3'(WAIT_STATES);
                  busy      <= 1'b1;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 3'd0)
                  state <= S_ACCESS;
               else
                  wait_cnt <= wait_cnt - 3'd1;
            end
            S_ACCESS: begin
               if (!lat_we) begin
                  if (own_host)
                     host_rdata <= mem[lat_addr];
                  else
                     data_in <= mem[lat_addr];
               end else if (blocked) begin
                  // Only the first violation's address is kept for post-mortem.
                  prot_err <= 1'b1;
                  if (!prot_err)
                     err_addr <= lat_addr;
               end
               if (own_host)
                  host_ready <= 1'b1;
               else
                  cpu_ready <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Bench for cpu_mem_ctrl: directed scenarios plus random host/CPU traffic, with a
// behavioural memory model feeding per-master expected queues that a monitor drains.
module tb_cpu_mem_ctrl;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int WS = 2;
   localparam int PL = 401;
   localparam int EW = 1 + DW + 1 + AW;

   logic          clk;
   logic          reset;
   logic          start_end;
   logic          cpu_req;
   logic          read_write;
   logic [AW-1:0] memory_address;
   logic [DW-1:0] data_out;
   logic [DW-1:0] data_in;
   logic          cpu_ready;
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic [DW-1:0] host_rdata;
   logic          host_ready;
   logic          busy;
   logic          prot_err;
   logic [AW-1:0] err_addr;
   logic [1:0]    state_dbg;

   cpu_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS), .PROT_LIMIT(PL)) dut (
      .clk(clk), .reset(reset), .start_end(start_end),
      .cpu_req(cpu_req), .read_write(read_write), .memory_address(memory_address),
      .data_out(data_out), .data_in(data_in), .cpu_ready(cpu_ready),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ready(host_ready),
      .busy(busy), .prot_err(prot_err), .err_addr(err_addr), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model and scoreboard ----------------
   logic [DW-1:0] ref_mem [int];
   int            keys[$];
   logic          m_perr;
   logic [AW-1:0] m_eaddr;
   logic [DW-1:0] last_host_rd;
   logic [DW-1:0] last_cpu_rd;
   logic [EW-1:0] host_q[$];
   logic [EW-1:0] cpu_q[$];
   bit            mon_en;
   int            checks;
   int            errors;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_perr       = 1'b0;
      m_eaddr      = '0;
      last_host_rd = '0;
      last_cpu_rd  = '0;
   endtask

   // Apply one access to the model and queue the response the owner should see.
   task automatic push_op(input bit host, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [DW-1:0] rd;
      rd = '0;
      if (we) begin
         if (!host && int'(a) < PL) begin
            if (!m_perr) m_eaddr = a;
            m_perr = 1'b1;
         end else begin
            if (!ref_mem.exists(int'(a))) keys.push_back(int'(a));
            ref_mem[int'(a)] = d;
         end
      end else begin
         rd = ref_mem[int'(a)];
         if (host) last_host_rd = rd;
         else      last_cpu_rd  = rd;
      end
      if (host) host_q.push_back({~we, rd, m_perr, m_eaddr});
      else      cpu_q.push_back({~we, rd, m_perr, m_eaddr});
   endtask

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (mon_en && host_ready === 1'b1) begin
         check("host_ready_pending", 32'(host_q.size() > 0), 1);
         if (host_q.size() > 0) begin
            e = host_q.pop_front();
            if (e[EW-1]) check("host_rdata", 32'(host_rdata), 32'(e[EW-2 -: DW]));
            check("host_prot_err", 32'(prot_err), 32'(e[AW]));
            check("host_err_addr", 32'(err_addr), 32'(e[AW-1:0]));
            check("data_in_hold", 32'(data_in), 32'(last_cpu_rd));
            check("no_cpu_ready", 32'(cpu_ready), 0);
         end
      end
      if (mon_en && cpu_ready === 1'b1) begin
         check("cpu_ready_pending", 32'(cpu_q.size() > 0), 1);
         if (cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            if (e[EW-1]) check("cpu_data_in", 32'(data_in), 32'(e[EW-2 -: DW]));
            check("cpu_prot_err", 32'(prot_err), 32'(e[AW]));
            check("cpu_err_addr", 32'(err_addr), 32'(e[AW-1:0]));
            check("host_rdata_hold", 32'(host_rdata), 32'(last_host_rd));
         end
      end
   end

   // ---------------- driver tasks (called just after a negedge) ----------------
   task automatic drive_op(input bit host, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (host) begin
         host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
      end else begin
         read_write = we; memory_address = a; data_out = d; cpu_req = 1'b1;
      end
   endtask

   // e0 = posedges already elapsed since the request was raised in IDLE.
   task automatic wait_ready(input bit host, input string name, input int e0);
      int edges;
      bit got;
      edges = e0;
      got   = 1'b0;
      while (!got && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         got = host ? host_ready : cpu_ready;
         if (edges == 1) check({name, "_busy"}, 32'(busy), 1);
      end
      check({name, "_ready_seen"}, 32'(got), 1);
      // Acceptance edge counts as edge 1 here; ready is sampled by edge WS+3.
      if (got) check({name, "_latency"}, edges, WS + 3);
      if (host) host_req = 1'b0;
      else      cpu_req  = 1'b0;
      @(negedge clk);
   endtask

   task automatic op(input bit host, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
      push_op(host, we, a, d);
      drive_op(host, we, a, d);
      wait_ready(host, name, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pulses;
      checks = 0; errors = 0; mon_en = 1'b0;
      reset = 1'b0; start_end = 1'b0;
      cpu_req = 1'b0; read_write = 1'b0; memory_address = '0; data_out = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data_in", 32'(data_in), 0);
      check("rst_host_rdata", 32'(host_rdata), 0);
      check("rst_err_addr", 32'(err_addr), 0);
      check("rst_cpu_ready", 32'(cpu_ready), 0);
      check("rst_host_ready", 32'(host_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_prot_err", 32'(prot_err), 0);
      reset  = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy), 0);
         check("idle_ready", 32'({cpu_ready, host_ready}), 0);
      end

      // Host load / readback and preloads.
      start_end = 1'b0;
      op(1, 1, 10'h000, 16'h1234, "host_wr0");
      op(1, 0, 10'h000, 16'h0000, "host_rd0");
      op(1, 1, 10'd401, 16'hBEEF, "host_pre401");
      op(1, 1, 10'd5,   16'h0F0F, "host_pre5");
      op(1, 1, 10'd7,   16'h0707, "host_pre7");

      // CPU read and protection.
      start_end = 1'b1;
      @(negedge clk);
      op(0, 0, 10'd401, 16'h0000, "cpu_rd401");
      repeat (3) @(negedge clk);
      check("data_in_held", 32'(data_in), 32'h0000BEEF);
      op(0, 1, 10'd5,   16'h5555, "cpu_wr5_blocked");
      op(0, 1, 10'd401, 16'hAAAA, "cpu_wr401");
      op(0, 1, 10'd7,   16'h1111, "cpu_wr7_blocked");
      check("err_addr_first", 32'(err_addr), 5);
      start_end = 1'b0;
      op(1, 0, 10'd5,   16'h0000, "host_rd5");
      op(1, 0, 10'd401, 16'h0000, "host_rd401");
      op(1, 0, 10'd7,   16'h0000, "host_rd7");

      // Host request while the CPU owns memory stays pending.
      start_end = 1'b1;
      @(negedge clk);
      push_op(1, 0, 10'h000, 16'h0000);
      drive_op(1, 0, 10'h000, 16'h0000);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (host_ready) pulses++;
      end
      check("arb_no_host_ready", pulses, 0);
      start_end = 1'b0;
      wait_ready(1, "arb_host", 0);

      // Ownership change during a CPU access does not abort it.
      start_end = 1'b1;
      @(negedge clk);
      push_op(0, 0, 10'd401, 16'h0000);
      drive_op(0, 0, 10'd401, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      check("toggle_in_wait", 32'(state_dbg), 1);
      start_end = 1'b0;
      wait_ready(0, "toggle_cpu", 1);

      // Randomised traffic.
      for (int n = 0; n < 60; n++) begin
         bit host, we;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         host = 1'($urandom_range(0, 1));
         we   = 1'($urandom_range(0, 1));
         d    = DW'($urandom);
         if (!we) a = AW'(keys[$urandom_range(0, keys.size() - 1)]);
         else if ($urandom_range(0, 2) == 0) a = AW'($urandom_range(0, PL - 1));
         else a = AW'($urandom_range(0, (1 << AW) - 1));
         start_end = !host;
         op(host, we, a, d, host ? "rnd_host" : "rnd_cpu");
      end

      // Reset during WAIT aborts the host write without touching memory.
      start_end = 1'b0;
      op(1, 1, 10'd10, 16'h0001, "host_pre10");
      drive_op(1, 1, 10'd10, 16'h9999);
      @(posedge clk);
      @(negedge clk);
      check("abort_in_wait", 32'(state_dbg), 1);
      reset = 1'b0;
      host_req = 1'b0;
      model_reset();
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_state", 32'(state_dbg), 0);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (host_ready) pulses++;
      end
      check("abort_no_ready", pulses, 0);
      check("abort_prot_clear", 32'(prot_err), 0);
      op(1, 0, 10'd10, 16'h0000, "host_rd10");

      check("host_q_drained", host_q.size(), 0);
      check("cpu_q_drained", cpu_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout: simulation did not reach the end");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
